sr_rx: RTL

SR_RX -- requirements
Module: sr_rx

---
 rtl/sr_rx.sv | 94 +++++++++
 1 files changed

// File: rtl/sr_rx.sv
// rtl/sr_rx.sv - serial shift-register receiver with latch strobe and bit-count check.
// Define SR_RX_SYNC2_EN for two-flop input synchronizers; undefined uses a single input register.
module sr_rx #(
    parameter int WIDTH = 40,
    parameter int CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sclk,
    input  logic             i_sdata,
    input  logic             i_latch,
    output logic [WIDTH-1:0] o_q,
    output logic             o_valid,
    output logic             o_err,
    output logic             o_busy
);

`ifdef SR_RX_SYNC2_EN
    localparam int N = 2;
`else
    localparam int N = 1;
`endif

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

    // Each synchronizer stage carries {latch, sdata, sclk}.
    logic [N-1:0][2:0] sync_q, sync_d;
    // Previous values for edge detection: {latch, sclk}.
    logic [1:0]        prev_q, prev_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              sclk_rise, latch_rise;

    always_comb begin
        sync_d    = '0;
        sync_d[0] = {i_latch, i_sdata, i_sclk};
        for (int i = 1; i < N; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d     = {sync_q[N-1][2], sync_q[N-1][0]};
        sclk_rise  = sync_q[N-1][0] & ~prev_q[0];
        latch_rise = sync_q[N-1][2] & ~prev_q[1];

        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        valid_d = 1'b0;
        err_d   = err_q;

        if (sclk_rise) begin
            shreg_d = {shreg_q[WIDTH-2:0], sync_q[N-1][1]};
            if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Latch sees the post-shift word and count when both edges coincide.
        if (latch_rise) begin
            q_d     = shreg_d;
            valid_d = 1'b1;
            err_d   = (cnt_d != CNT_FULL);
            cnt_d   = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q  <= '1;
            prev_q  <= '1;
            shreg_q <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign o_q     = q_q;
    assign o_valid = valid_q;
    assign o_err   = err_q;
    assign o_busy  = (cnt_q != '0);

endmodule
